// File: rtl/divider_32bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake and a divide-by-zero shortcut.
module divider_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             fits;
  logic             last_iter;
  logic             accept;

  // R < divisor always holds, so dropping R[WIDTH] on the shift loses nothing
  always_comb begin
    rem_sh    = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
    trial     = rem_sh - {1'b0, dvsr_r};
    fits      = ~trial[WIDTH];
    rem_nxt   = fits ? trial : rem_sh;
    q_nxt     = {q_r[WIDTH-2:0], fits};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
    accept    = (state == S_IDLE) && start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Result registers load only on entry to DONE, so they hold across later runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r       <= '0;
      q_r         <= '0;
      dvsr_r      <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      rem_r  <= '0;
      q_r    <= dividend;
      dvsr_r <= divisor;
      cnt    <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == S_RUN) begin
      rem_r <= rem_nxt;
      q_r   <= q_nxt;
      cnt   <= cnt + 1'b1;
      if (last_iter) begin
        quotient    <= q_nxt;
        remainder   <= rem_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_32bit_seq.sv
// Scoreboard bench for divider_32bit_seq: expected results are queued when an
// operation is issued and popped when done pulses.
module tb_divider_32bit_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  divider_32bit_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      e.q = 'x;
      e.r = 'x;
      e.dz = 1'bx;
    end else begin
      e = sb.pop_front();
    end
  endtask

  // Drives a one-cycle start; returns at the negedge just after the capture edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_n, output bit ok);
    edges = 0;
    busy_n = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      edges++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dz=%b exp all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int edges, busy_n;
    bit ok;
    exp_t e;
    issue(32'd100, 32'd7);
    wait_done(edges, busy_n, ok);
    pop_exp(e);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout got no done exp done within 100 cycles");
    end
    total++;
    if (edges + 1 !== 33) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=33", edges + 1);
    end
    total++;
    if (busy_n !== 32) begin
      bad++;
      $display("FAIL basic_busy_cycles got=%0d exp=32", busy_n);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} ||
        quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL basic_result got q=%0d r=%0d dz=%b exp q=14 r=2 dz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_max;
    int edges, busy_n;
    bit ok;
    exp_t e;
    logic [W-1:0] ops_a[2];
    logic [W-1:0] ops_b[2];
    ops_a[0] = 32'hFFFF_FFFF; ops_b[0] = 32'd1;
    ops_a[1] = 32'hFFFF_FFFF; ops_b[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      issue(ops_a[i], ops_b[i]);
      wait_done(edges, busy_n, ok);
      pop_exp(e);
      total++;
      if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
        bad++;
        $display("FAIL max_%0d got q=%h r=%h dz=%b ok=%b exp q=%h r=%h dz=%b",
                 i, quotient, remainder, div_by_zero, ok, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_small;
    int edges, busy_n;
    bit ok;
    exp_t e;
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    ops_a[0] = 32'd3;   ops_b[0] = 32'd10;
    ops_a[1] = 32'd0;   ops_b[1] = 32'd5;
    ops_a[2] = 32'hDEAD_BEEF; ops_b[2] = 32'h0001_2345;
    for (int i = 0; i < 3; i++) begin
      issue(ops_a[i], ops_b[i]);
      wait_done(edges, busy_n, ok);
      pop_exp(e);
      total++;
      if (!ok || edges + 1 !== 33 ||
          {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
        bad++;
        $display("FAIL small_%0d got q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=%b lat=33",
                 i, quotient, remainder, div_by_zero, edges + 1, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_div_zero;
    int edges, busy_n;
    bit ok;
    exp_t e;
    issue(32'h1234_5678, 32'd0);
    wait_done(edges, busy_n, ok);
    pop_exp(e);
    total++;
    if (!ok || edges + 1 !== 1 || busy_n !== 0) begin
      bad++;
      $display("FAIL dz_timing got lat=%0d busy_cycles=%0d exp lat=1 busy_cycles=0",
               edges + 1, busy_n);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} ||
        remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_result got q=%h r=%h dz=%b exp q=ffffffff r=12345678 dz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL dz_after got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_ignored;
    int dc0, edges;
    bit held;
    exp_t e;
    dc0 = done_cnt;
    issue(32'd1000, 32'd3);
    held = 1'b1;
    repeat (8) begin
      if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) held = 1'b0;
      @(negedge clk);
    end
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd9;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) held = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      @(negedge clk);
      edges++;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL hold_during_run got changed outputs exp q=ffffffff r=12345678 dz=1 held");
    end
    pop_exp(e);
    total++;
    if (done !== 1'b1 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} ||
        quotient !== 32'd333 || remainder !== 32'd1) begin
      bad++;
      $display("FAIL ignored_result got q=%0d r=%0d dz=%b done=%b exp q=333 r=1 dz=0 done=1",
               quotient, remainder, div_by_zero, done);
    end
    dividend = 32'd0;
    divisor = 32'd0;
    repeat (40) @(negedge clk);
    total++;
    if (done_cnt - dc0 !== 1 || busy !== 1'b0 ||
        quotient !== 32'd333 || remainder !== 32'd1) begin
      bad++;
      $display("FAIL ignored_not_queued got dones=%0d busy=%b q=%0d r=%0d exp dones=1 busy=0 q=333 r=1",
               done_cnt - dc0, busy, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int edges, busy_n;
    bit ok;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    dividend = 32'd20;
    divisor = 32'd6;
    push_exp(32'd20, 32'd6);
    @(negedge clk);
    dividend = 32'd77;
    divisor = 32'd5;
    push_exp(32'd77, 32'd5);
    wait_done(edges, busy_n, ok);
    pop_exp(e);
    total++;
    if (!ok || edges + 1 !== 33 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      bad++;
      $display("FAIL b2b_first got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=33",
               quotient, remainder, edges + 1, e.q, e.r);
    end
    @(negedge clk);
    wait_done(edges, busy_n, ok);
    start = 1'b0;
    pop_exp(e);
    total++;
    if (!ok || edges + 1 !== 34 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      bad++;
      $display("FAIL b2b_second got q=%0d r=%0d gap=%0d exp q=%0d r=%0d gap=34",
               quotient, remainder, edges + 1, e.q, e.r);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int edges, busy_n, dc0;
    bit ok;
    exp_t e;
    issue(32'd50, 32'd4);
    repeat (13) @(negedge clk);
    dc0 = done_cnt;
    #2;
    rst_n = 1'b0;
    pop_exp(e);
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_mid_clear got busy=%b done=%b q=%h r=%h dz=%b exp all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (40) @(negedge clk);
    total++;
    if (done_cnt !== dc0) begin
      bad++;
      $display("FAIL reset_mid_no_done got dones=%0d exp 0", done_cnt - dc0);
    end
    rst_n = 1'b1;
    issue(32'd50, 32'd4);
    wait_done(edges, busy_n, ok);
    pop_exp(e);
    total++;
    if (!ok || edges + 1 !== 33 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} ||
        quotient !== 32'd12 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL reset_mid_fresh got q=%0d r=%0d lat=%0d exp q=12 r=2 lat=33",
               quotient, remainder, edges + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_small();
    test_div_zero();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0 pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
